sandbox_host_bridge: RTL and testbench
======================================

# sandbox_host_bridge

Host-side counterpart of the sandbox process handshake. Assembles 5-byte command frames from the UART receive byte stream into a control byte plus a 32-bit data word and presents them on the dataReceived/control/inputData interface. It returns the process's status byte and 32-bit result as a 5-byte response frame to the UART transmitter. It sits between the UART byte engines and the sandbox process.

## Interface
- TIMEOUT_CYCLES, 1000000: idle cycles inside a partial command frame before the partial frame is discarded (minimum 2).
- masterClock  in  1  operating clock.
- reset  in  1  synchronous, active-low.
- rxByteValid  in  1  one-cycle strobe: rxByte valid.
- rxByte  in  8  received byte.
- txByteValid  out  1  txByte valid; held until accepted.
- txByte  out  8  byte to transmit.
- txByteReady  in  1  transmitter accepts txByte when txByteValid && txByteReady.
- dataReceived  out  1  complete command frame held for the process.
- control  out  8  frame byte 0.
- inputData  out  32  frame bytes 1..4, big-endian.
- clearDR  in  1  process releases the frame.
- transmitData  in  1  level request; its rising edge starts one response.
- status  in  8  response byte 0.
- outputData  in  32  response bytes 1..4, big-endian.
- txBusy  out  1  response frame in progress.
- rxOverrun  out  1  sticky: byte dropped because dataReceived was 1.
- rxTimeout  out  1  sticky: partial frame discarded.
- txDropped  out  1  sticky: transmitData rising edge ignored because txBusy was 1.

## Operation
- Reset (reset==0 at a clock edge) clears all outputs, byte index, timeout counter, TX state and shadow registers, including sticky flags. Reset mid-frame or mid-response abandons the frame with no further txByteValid. Sticky flags clear only on reset.
- RX assembler:
  - Byte index 0..4. Each accepted byte is written to its slot: 0 → control, 1 → inputData[31:24], …, 4 → inputData[7:0].
  - After slot 4: dataReceived=1 and index returns to 0.
  - control and inputData stay stable while dataReceived=1.
- Release: clearDR==1 while dataReceived==1 clears dataReceived. clearDR while dataReceived==0 is ignored.
- Overrun:
  - rxByteValid while dataReceived==1 drops the byte and sets rxOverrun.
  - If clearDR and rxByteValid occur in the same cycle, the byte is dropped and rxOverrun is set.
- Timeout:
  - The counter resets on every accepted byte and runs only while index is 1..4.
  - After TIMEOUT_CYCLES consecutive cycles without a byte, index returns to 0 and rxTimeout is set.
  - A byte arriving in the same cycle the limit is reached is accepted, and no timeout occurs.
- TX FSM states:
  - IDLE → LOAD on a transmitData rising edge (registered previous value 0, current value 1).
  - LOAD captures status and outputData into a 40-bit shadow register, with byteCount=0 → SEND.
  - SEND drives txByte from shadow[39:32], with txByteValid=1. On handshake, shift the shadow left 8 and increment byteCount. After the 5th handshake → IDLE.
  - txBusy=1 in LOAD and SEND.
- A transmitData rising edge while txBusy=1 is ignored and sets txDropped.
- RX and TX operate independently and concurrently.

## Timing
- Byte strobe on slot 4 in cycle N → dataReceived=1 and control/inputData valid from cycle N+1.
- clearDR sampled high in cycle N → dataReceived=0 from N+1.
- transmitData rising edge sampled in cycle N → LOAD in N+1 → txByteValid=1 with the status byte from N+2.
- Each byte occupies at least 1 cycle. With txByteReady held at 1, a response takes 5 consecutive cycles and txBusy=0 the cycle after the last handshake.
- txByte and txByteValid do not change while txByteValid=1 and txByteReady=0.
- A new response can be requested the cycle after txBusy falls.

## Structure
- Package sandbox_link_pkg holds:
  - FRAME_BYTES=5.
  - TX state encoding (IDLE, LOAD, SEND).
  - Byte-slot constants.
- Natural sub-module: sandbox_frame_serializer, containing the TX FSM, shadow register and byte counter. The RX assembler, timeout and edge detect live in the top.
- Timeout counter width is $clog2(TIMEOUT_CYCLES+1).

## Test plan
- Bytes 01,12,34,56,78 on consecutive cycles, then clearDR pulse → dataReceived=1 one cycle after the 5th byte, with control=01 and inputData=12345678; dataReceived=0 one cycle after clearDR.
- status=03, outputData=DEADBEEF, transmitData 0→1, txByteReady=1 → txByteValid from edge+2, bytes 03,DE,AD,BE,EF on 5 consecutive cycles, then txBusy=0.
- Same response with txByteReady toggling 1,0,0,1,… → every byte is held stable through the ready=0 cycles, and none is duplicated or skipped.
- TIMEOUT_CYCLES=16: bytes 01,AA, then 16 idle cycles → rxTimeout=1, no dataReceived. A following 5-byte frame 02,00,00,00,07 → control=02, inputData=00000007.
- Frame held (dataReceived=1), byte 55 strobed in the same cycle as clearDR → dataReceived=0, rxOverrun=1, and 55 does not appear in the next frame.
- A second transmitData rising edge during an active response → txDropped=1, exactly 5 bytes sent; reset asserted mid-response → txByteValid=0 and all flags 0 the next cycle.

Source files
------------

// File: rtl/sandbox_link_pkg.sv
// Shared constants for the sandbox host link: frame geometry, TX state encoding
// and byte-slot numbering, plus the helper that drops a byte into the data word.
package sandbox_link_pkg;

  localparam int FRAME_BYTES = 5;

  localparam logic [1:0] TX_IDLE = 2'd0;
  localparam logic [1:0] TX_LOAD = 2'd1;
  localparam logic [1:0] TX_SEND = 2'd2;

  localparam logic [2:0] SLOT_CONTROL  = 3'd0;
  localparam logic [2:0] SLOT_LAST     = 3'd4;
  localparam logic [2:0] TX_LAST_COUNT = 3'd4;

  // Slot 1 is the most significant data byte (big-endian on the wire).
  function automatic logic [31:0] put_data_byte(input logic [31:0] word,
                                                input logic [2:0]  slot,
                                                input logic [7:0]  b);
    logic [31:0] r;
    r = word;
    case (slot)
      3'd1:    r[31:24] = b;
      3'd2:    r[23:16] = b;
      3'd3:    r[15:8]  = b;
      3'd4:    r[7:0]   = b;
      default: r = word;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/sandbox_frame_serializer.sv
// Response serializer: captures status + result into a 40-bit shadow and
// hands it to the UART transmitter one byte per handshake, MSB first.
module sandbox_frame_serializer
  import sandbox_link_pkg::*;
(
  input  logic        masterClock,
  input  logic        reset,
  input  logic        start_i,
  input  logic [7:0]  status_i,
  input  logic [31:0] data_i,
  input  logic        tx_ready_i,
  output logic        tx_valid_o,
  output logic [7:0]  tx_byte_o,
  output logic        tx_busy_o
);

  logic [1:0]  state_q, state_d;
  logic [39:0] shadow_q, shadow_d;
  logic [2:0]  count_q, count_d;

  // Next-state logic for the IDLE -> LOAD -> SEND sequence.
  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    count_d  = count_q;
    case (state_q)
      TX_IDLE: begin
        if (start_i) state_d = TX_LOAD;
        else         state_d = TX_IDLE;
      end
      TX_LOAD: begin
        shadow_d = {status_i, data_i};
        count_d  = 3'd0;
        state_d  = TX_SEND;
      end
      TX_SEND: begin
        if (tx_ready_i) begin
          shadow_d = {shadow_q[31:0], 8'h00};
          if (count_q == TX_LAST_COUNT) begin
            count_d = 3'd0;
            state_d = TX_IDLE;
          end else begin
            count_d = count_q + 3'd1;
            state_d = TX_SEND;
          end
        end else begin
          state_d = TX_SEND;
        end
      end
      default: begin
        state_d  = TX_IDLE;
        shadow_d = 40'h0;
        count_d  = 3'd0;
      end
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge masterClock) begin
    if (!reset) begin
      state_q  <= TX_IDLE;
      shadow_q <= 40'h0;
      count_q  <= 3'd0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      count_q  <= count_d;
    end
  end

  assign tx_valid_o = (state_q == TX_SEND);
  assign tx_byte_o  = shadow_q[39:32];
  assign tx_busy_o  = (state_q != TX_IDLE);

endmodule

// File: rtl/sandbox_host_bridge.sv
// Host side of the sandbox handshake: assembles 5-byte command frames from UART
// RX bytes and returns status/result frames through the serializer.
module sandbox_host_bridge
  import sandbox_link_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic        masterClock,
  input  logic        reset,
  input  logic        rxByteValid,
  input  logic [7:0]  rxByte,
  output logic        txByteValid,
  output logic [7:0]  txByte,
  input  logic        txByteReady,
  output logic        dataReceived,
  output logic [7:0]  control,
  output logic [31:0] inputData,
  input  logic        clearDR,
  input  logic        transmitData,
  input  logic [7:0]  status,
  input  logic [31:0] outputData,
  output logic        txBusy,
  output logic        rxOverrun,
  output logic        rxTimeout,
  output logic        txDropped
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TMO_ONE  = TW'(1);

  logic [2:0]    idx_q, idx_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          dr_q, dr_d;
  logic [7:0]    control_q, control_d;
  logic [31:0]   data_q, data_d;
  logic          ovr_q, ovr_d;
  logic          rxto_q, rxto_d;
  logic          drop_q, drop_d;
  logic          td_prev_q;
  logic          tx_rise_s, tx_start_s, tx_busy_s;

  // RX frame assembly, release, overrun and partial-frame timeout.
  always_comb begin
    idx_d     = idx_q;
    tmo_d     = tmo_q;
    dr_d      = dr_q;
    control_d = control_q;
    data_d    = data_q;
    ovr_d     = ovr_q;
    rxto_d    = rxto_q;
    if (dr_q) begin
      dr_d  = ~clearDR;
      tmo_d = {TW{1'b0}};
      if (rxByteValid) ovr_d = 1'b1;
      else             ovr_d = ovr_q;
    end else if (rxByteValid) begin
      tmo_d = {TW{1'b0}};
      if (idx_q == SLOT_CONTROL) control_d = rxByte;
      else                       data_d    = put_data_byte(data_q, idx_q, rxByte);
      if (idx_q == SLOT_LAST) begin
        idx_d = SLOT_CONTROL;
        dr_d  = 1'b1;
      end else begin
        idx_d = idx_q + 3'd1;
        dr_d  = 1'b0;
      end
    end else if (idx_q != SLOT_CONTROL) begin
      // A byte in the limit cycle takes the branch above, so it always wins.
      if (tmo_q == TMO_LAST) begin
        idx_d  = SLOT_CONTROL;
        tmo_d  = {TW{1'b0}};
        rxto_d = 1'b1;
      end else begin
        tmo_d = tmo_q + TMO_ONE;
      end
    end else begin
      tmo_d = {TW{1'b0}};
    end
  end

  assign tx_rise_s  = transmitData & ~td_prev_q;
  assign tx_start_s = tx_rise_s & ~tx_busy_s;
  assign drop_d     = drop_q | (tx_rise_s & tx_busy_s);

  // RX registers, sticky flags and the transmitData edge history.
  always_ff @(posedge masterClock) begin
    if (!reset) begin
      idx_q     <= SLOT_CONTROL;
      tmo_q     <= {TW{1'b0}};
      dr_q      <= 1'b0;
      control_q <= 8'h00;
      data_q    <= 32'h0;
      ovr_q     <= 1'b0;
      rxto_q    <= 1'b0;
      drop_q    <= 1'b0;
      td_prev_q <= 1'b0;
    end else begin
      idx_q     <= idx_d;
      tmo_q     <= tmo_d;
      dr_q      <= dr_d;
      control_q <= control_d;
      data_q    <= data_d;
      ovr_q     <= ovr_d;
      rxto_q    <= rxto_d;
      drop_q    <= drop_d;
      td_prev_q <= transmitData;
    end
  end

  sandbox_frame_serializer u_serializer (
    .masterClock (masterClock),
    .reset       (reset),
    .start_i     (tx_start_s),
    .status_i    (status),
    .data_i      (outputData),
    .tx_ready_i  (txByteReady),
    .tx_valid_o  (txByteValid),
    .tx_byte_o   (txByte),
    .tx_busy_o   (tx_busy_s)
  );

  assign txBusy       = tx_busy_s;
  assign dataReceived = dr_q;
  assign control      = control_q;
  assign inputData    = data_q;
  assign rxOverrun    = ovr_q;
  assign rxTimeout    = rxto_q;
  assign txDropped    = drop_q;

endmodule

// File: tb/tb_sandbox_host_bridge.sv
// Self-checking bench for sandbox_host_bridge: vector table, directed TX/timeout
// sequences and randomized traffic against a queue-based reference model.
module tb_sandbox_host_bridge;

  localparam int TO = 16;

  logic        masterClock = 1'b0;
  logic        reset, rxByteValid, txByteReady, clearDR, transmitData;
  logic [7:0]  rxByte, status;
  logic [31:0] outputData;
  logic        txByteValid, dataReceived, txBusy, rxOverrun, rxTimeout, txDropped;
  logic [7:0]  txByte, control;
  logic [31:0] inputData;

  always #5 masterClock = ~masterClock;

  sandbox_host_bridge #(.TIMEOUT_CYCLES(TO)) dut (
    .masterClock(masterClock), .reset(reset),
    .rxByteValid(rxByteValid), .rxByte(rxByte),
    .txByteValid(txByteValid), .txByte(txByte), .txByteReady(txByteReady),
    .dataReceived(dataReceived), .control(control), .inputData(inputData),
    .clearDR(clearDR), .transmitData(transmitData), .status(status),
    .outputData(outputData), .txBusy(txBusy), .rxOverrun(rxOverrun),
    .rxTimeout(rxTimeout), .txDropped(txDropped)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference model: frames as byte queues, responses as queues of pending bytes.
  logic       m_dr, m_ovr, m_to, m_drop, m_prev, m_load;
  logic [7:0] m_ctrl;
  logic [31:0] m_data;
  logic [7:0] m_buf[$];
  logic [7:0] m_txq[$];
  logic [7:0] hs_q[$];
  int         m_idle;

  task automatic model_update();
    logic rise, busy;
    if (!reset) begin
      m_dr = 0; m_ovr = 0; m_to = 0; m_drop = 0; m_prev = 0; m_load = 0;
      m_ctrl = 8'h00; m_data = 32'h0; m_buf.delete(); m_txq.delete(); m_idle = 0;
    end else begin
      if (m_dr) begin
        if (rxByteValid) m_ovr = 1;
        if (clearDR) m_dr = 0;
      end else if (rxByteValid) begin
        m_buf.push_back(rxByte);
        m_idle = 0;
        if (m_buf.size() == 5) begin
          m_ctrl = m_buf[0];
          m_data = {m_buf[1], m_buf[2], m_buf[3], m_buf[4]};
          m_dr = 1;
          m_buf.delete();
        end
      end else if (m_buf.size() != 0) begin
        m_idle++;
        if (m_idle == TO) begin
          m_buf.delete(); m_idle = 0; m_to = 1;
        end
      end
      rise = transmitData && !m_prev;
      m_prev = transmitData;
      busy = m_load || (m_txq.size() != 0);
      if (m_txq.size() != 0 && txByteReady) void'(m_txq.pop_front());
      if (m_load) begin
        m_txq.push_back(status);
        for (int k = 3; k >= 0; k--) m_txq.push_back(outputData[k*8 +: 8]);
        m_load = 0;
      end
      if (rise) begin
        if (busy) m_drop = 1;
        else      m_load = 1;
      end
    end
  endtask

  task automatic model_check();
    chk("m_dataReceived", dataReceived, m_dr);
    if (m_dr) begin
      chk("m_control", control, m_ctrl);
      chk("m_inputData", inputData, m_data);
    end
    chk("m_txByteValid", txByteValid, m_txq.size() != 0);
    if (m_txq.size() != 0) chk("m_txByte", txByte, m_txq[0]);
    chk("m_txBusy", txBusy, m_load || (m_txq.size() != 0));
    chk("m_rxOverrun", rxOverrun, m_ovr);
    chk("m_rxTimeout", rxTimeout, m_to);
    chk("m_txDropped", txDropped, m_drop);
  endtask

  task automatic tick();
    if (txByteValid && txByteReady) hs_q.push_back(txByte);
    model_update();
    @(posedge masterClock);
    #1;
    model_check();
  endtask

  typedef struct {
    logic        v;
    logic [7:0]  b;
    logic        clr;
    logic        edr;
    logic [7:0]  ectl;
    logic [31:0] edat;
    logic        eovr;
  } rx_vec_t;

  rx_vec_t tbl[19];
  logic [7:0] exp5[5];
  logic [7:0] held;
  logic       was_held;
  int rate;

  initial begin
    tbl[0]  = '{1'b1, 8'h01, 1'b0, 1'b0, 8'h00, 32'h0, 1'b0};
    tbl[1]  = '{1'b1, 8'h12, 1'b0, 1'b0, 8'h00, 32'h0, 1'b0};
    tbl[2]  = '{1'b1, 8'h34, 1'b0, 1'b0, 8'h00, 32'h0, 1'b0};
    tbl[3]  = '{1'b1, 8'h56, 1'b0, 1'b0, 8'h00, 32'h0, 1'b0};
    tbl[4]  = '{1'b1, 8'h78, 1'b0, 1'b1, 8'h01, 32'h12345678, 1'b0};
    tbl[5]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h01, 32'h12345678, 1'b0};
    tbl[6]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 32'h0, 1'b0};
    tbl[7]  = '{1'b1, 8'hAB, 1'b0, 1'b0, 8'h00, 32'h0, 1'b0};
    tbl[8]  = '{1'b1, 8'hCD, 1'b0, 1'b0, 8'h00, 32'h0, 1'b0};
    tbl[9]  = '{1'b1, 8'hEF, 1'b0, 1'b0, 8'h00, 32'h0, 1'b0};
    tbl[10] = '{1'b1, 8'h01, 1'b0, 1'b0, 8'h00, 32'h0, 1'b0};
    tbl[11] = '{1'b1, 8'h23, 1'b0, 1'b1, 8'hAB, 32'hCDEF0123, 1'b0};
    tbl[12] = '{1'b1, 8'h55, 1'b1, 1'b0, 8'h00, 32'h0, 1'b1};
    tbl[13] = '{1'b1, 8'h11, 1'b0, 1'b0, 8'h00, 32'h0, 1'b1};
    tbl[14] = '{1'b1, 8'h22, 1'b0, 1'b0, 8'h00, 32'h0, 1'b1};
    tbl[15] = '{1'b1, 8'h33, 1'b0, 1'b0, 8'h00, 32'h0, 1'b1};
    tbl[16] = '{1'b1, 8'h44, 1'b0, 1'b0, 8'h00, 32'h0, 1'b1};
    tbl[17] = '{1'b1, 8'h66, 1'b0, 1'b1, 8'h11, 32'h22334466, 1'b1};
    tbl[18] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 32'h0, 1'b1};
    exp5 = '{8'h03, 8'hDE, 8'hAD, 8'hBE, 8'hEF};

    reset = 1'b0; rxByteValid = 1'b0; rxByte = 8'h00; clearDR = 1'b0;
    transmitData = 1'b0; txByteReady = 1'b1; status = 8'h00; outputData = 32'h0;
    tick(); tick();
    chk("rst_control", control, 8'h00);
    chk("rst_inputData", inputData, 32'h0);
    chk("rst_txByte", txByte, 8'h00);
    reset = 1'b1;
    tick();

    // Frame assembly, release and overrun vectors.
    for (int i = 0; i < 19; i++) begin
      rxByteValid = tbl[i].v; rxByte = tbl[i].b; clearDR = tbl[i].clr;
      tick();
      chk($sformatf("vec%0d_dr", i), dataReceived, tbl[i].edr);
      chk($sformatf("vec%0d_ovr", i), rxOverrun, tbl[i].eovr);
      if (tbl[i].edr) begin
        chk($sformatf("vec%0d_ctrl", i), control, tbl[i].ectl);
        chk($sformatf("vec%0d_data", i), inputData, tbl[i].edat);
      end
    end
    rxByteValid = 1'b0; clearDR = 1'b0;

    // Response with ready held high: LOAD at edge+1, bytes from edge+2.
    status = 8'h03; outputData = 32'hDEADBEEF; txByteReady = 1'b1;
    transmitData = 1'b1;
    tick();
    chk("tx_load_valid", txByteValid, 1'b0);
    chk("tx_load_busy", txBusy, 1'b1);
    tick();
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("tx_b%0d_valid", i), txByteValid, 1'b1);
      chk($sformatf("tx_b%0d_byte", i), txByte, exp5[i]);
      tick();
    end
    chk("tx_end_busy", txBusy, 1'b0);
    chk("tx_end_valid", txByteValid, 1'b0);
    transmitData = 1'b0;
    tick();

    // Response with ready toggling 1,0,0,1.
    hs_q.delete();
    transmitData = 1'b1;
    for (int k = 0; k < 40; k++) begin
      txByteReady = (k % 4 == 0) || (k % 4 == 3);
      was_held = txByteValid && !txByteReady;
      held = txByte;
      tick();
      if (was_held) begin
        chk("toggle_hold_valid", txByteValid, 1'b1);
        chk("toggle_hold_byte", txByte, held);
      end
      if (hs_q.size() >= 5 && !txBusy) break;
    end
    chk("toggle_count", hs_q.size(), 5);
    for (int i = 0; i < 5 && i < hs_q.size(); i++) chk($sformatf("toggle_b%0d", i), hs_q[i], exp5[i]);
    transmitData = 1'b0; txByteReady = 1'b1;
    tick();

    // Partial frame timeout, then a clean frame.
    rxByteValid = 1'b1; rxByte = 8'h01; tick();
    rxByte = 8'hAA; tick();
    rxByteValid = 1'b0;
    for (int i = 0; i < TO - 1; i++) tick();
    chk("to_before_limit", rxTimeout, 1'b0);
    tick();
    chk("to_at_limit", rxTimeout, 1'b1);
    chk("to_no_dr", dataReceived, 1'b0);
    rxByteValid = 1'b1;
    rxByte = 8'h02; tick();
    rxByte = 8'h00; tick(); tick(); tick();
    rxByte = 8'h07; tick();
    rxByteValid = 1'b0;
    chk("to_frame_dr", dataReceived, 1'b1);
    chk("to_frame_ctrl", control, 8'h02);
    chk("to_frame_data", inputData, 32'h00000007);
    clearDR = 1'b1; tick(); clearDR = 1'b0;

    // Second rising edge mid-response is dropped; exactly 5 bytes go out.
    hs_q.delete();
    transmitData = 1'b1; tick();
    tick();
    transmitData = 1'b0; tick();
    transmitData = 1'b1; tick();
    chk("drop_flag", txDropped, 1'b1);
    for (int k = 0; k < 20; k++) begin
      if (!txBusy) break;
      tick();
    end
    tick(); tick(); tick();
    chk("drop_count", hs_q.size(), 5);
    chk("drop_idle", txBusy, 1'b0);

    // Reset in the middle of a response.
    transmitData = 1'b0; tick();
    transmitData = 1'b1; tick(); tick(); tick();
    reset = 1'b0; tick();
    chk("rst_mid_valid", txByteValid, 1'b0);
    chk("rst_mid_busy", txBusy, 1'b0);
    chk("rst_mid_ovr", rxOverrun, 1'b0);
    chk("rst_mid_to", rxTimeout, 1'b0);
    chk("rst_mid_drop", txDropped, 1'b0);
    reset = 1'b1; transmitData = 1'b0; tick();

    // Randomized traffic against the model.
    for (int seg = 0; seg < 20; seg++) begin
      case (seg % 3)
        0:       rate = 60;
        1:       rate = 5;
        default: rate = 25;
      endcase
      for (int c = 0; c < 200; c++) begin
        rxByteValid = ($urandom_range(99) < rate);
        rxByte      = 8'($urandom);
        clearDR     = ($urandom_range(7) == 0);
        if ($urandom_range(7) == 0) transmitData = ~transmitData;
        txByteReady = ($urandom_range(3) != 0);
        status      = 8'($urandom);
        outputData  = $urandom;
        reset       = ($urandom_range(599) != 0);
        tick();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
